// File: rtl/accel_dma_cmd_engine.sv
// accel_dma_cmd_engine: paged per-channel command/status queues, round-robin onto one tagged AXIS
// command stream. Define ACCEL_DMA_CMD_IRQ_EN for the per-channel irq outputs and IRQ_MASK register.
module accel_dma_cmd_engine #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_CHANNELS     = 4,
    parameter int C_PAGEWIDTH        = 12,
    parameter int C_CMD_DEPTH        = 8,
    parameter int C_STS_DEPTH        = 8,
    localparam int CHW = $clog2(C_NUM_CHANNELS)
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
    input  logic                          set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
    input  logic                          get_stb,
    output logic                          M_AXIS_CMD_TVALID,
    input  logic                          M_AXIS_CMD_TREADY,
    output logic [71:0]                   M_AXIS_CMD_TDATA,
    output logic [CHW-1:0]                M_AXIS_CMD_TDEST,
    input  logic                          S_AXIS_STS_TVALID,
    output logic                          S_AXIS_STS_TREADY,
    input  logic [7:0]                    S_AXIS_STS_TDATA,
    input  logic [CHW-1:0]                S_AXIS_STS_TDEST
`ifdef ACCEL_DMA_CMD_IRQ_EN
    ,
    output logic [C_NUM_CHANNELS-1:0]     irq
`endif
);
    // state | meaning
    // IDLE  | no command presented; picks first non-empty channel at/after rr_ptr
    // BUSY  | head of granted FIFO held on M_AXIS_CMD until accepted
    localparam int N   = C_NUM_CHANNELS;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int PW  = C_PAGEWIDTH;
    localparam int CAW = $clog2(C_CMD_DEPTH);
    localparam int SAW = $clog2(C_STS_DEPTH);
    localparam logic [PW-1:0] OFS_ADDR   = PW'(8'h00);
    localparam logic [PW-1:0] OFS_CTRL   = PW'(8'h04);
    localparam logic [PW-1:0] OFS_STAT   = PW'(8'h08);
    localparam logic [PW-1:0] OFS_POP    = PW'(8'h0C);
    localparam logic [PW-1:0] OFS_ISSUED = PW'(8'h10);
    localparam logic [PW-1:0] OFS_DONE   = PW'(8'h14);
`ifdef ACCEL_DMA_CMD_IRQ_EN
    localparam logic [PW-1:0] OFS_MASK   = PW'(8'h18);
    logic [1:0] irq_mask [N];
    logic       wr_mask;
`endif

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
    state_t state, state_nxt;

    logic           running, load, cmd_hs, sts_hs, sts_stall, grant_vld;
    logic [8:0]     stall_tmr;
    logic [CHW-1:0] rr_ptr, grant, set_ch, get_ch;
    logic [AW-1:0]  set_page, get_page;
    logic [PW-1:0]  set_ofs, get_ofs;
    logic           set_hit, get_hit, wr_addr, wr_ctrl, wr_stat, rd_pop;
    logic [31:0]    addr_stage [N];
    logic [3:0]     tag_cnt [N];
    logic [31:0]    issued_cnt [N];
    logic [31:0]    done_cnt [N];
    logic [67:0]    cmd_mem [N][C_CMD_DEPTH];
    logic [7:0]     sts_mem [N][C_STS_DEPTH];
    logic [CAW:0]   cmd_wr [N], cmd_rd [N], cmd_cnt [N];
    logic [SAW:0]   sts_wr [N], sts_rd [N], sts_cnt [N];
    logic [N-1:0]   cmd_empty, cmd_full, sts_empty, sts_full;
    logic [N-1:0]   cmd_push, cmd_pop, sts_push, sts_pop, set_sel, cmd_ovf, sts_ovf;

    // Pages above the channel count must not alias onto real channels.
    assign set_page = set_addr >> PW;
    assign get_page = get_addr >> PW;
    assign set_ofs  = set_addr[PW-1:0];
    assign get_ofs  = get_addr[PW-1:0];
    assign set_ch   = set_addr[PW +: CHW];
    assign get_ch   = get_addr[PW +: CHW];
    assign set_hit  = set_stb && (set_page < AW'(N));
    assign get_hit  = get_page < AW'(N);
    assign wr_addr  = set_hit && (set_ofs == OFS_ADDR);
    assign wr_ctrl  = set_hit && (set_ofs == OFS_CTRL);
    assign wr_stat  = set_hit && (set_ofs == OFS_STAT);
    assign rd_pop   = get_stb && get_hit && (get_ofs == OFS_POP);
`ifdef ACCEL_DMA_CMD_IRQ_EN
    assign wr_mask  = set_hit && (set_ofs == OFS_MASK);
`endif

    assign S_AXIS_STS_TREADY = running && !sts_full[S_AXIS_STS_TDEST];
    assign sts_hs    = S_AXIS_STS_TVALID && S_AXIS_STS_TREADY;
    assign sts_stall = running && S_AXIS_STS_TVALID && sts_full[S_AXIS_STS_TDEST];
    assign cmd_hs    = M_AXIS_CMD_TVALID && M_AXIS_CMD_TREADY;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cmd_cnt[i]   = cmd_wr[i] - cmd_rd[i];
            sts_cnt[i]   = sts_wr[i] - sts_rd[i];
            cmd_empty[i] = cmd_cnt[i] == '0;
            cmd_full[i]  = cmd_cnt[i] == (CAW+1)'(C_CMD_DEPTH);
            sts_empty[i] = sts_cnt[i] == '0;
            sts_full[i]  = sts_cnt[i] == (SAW+1)'(C_STS_DEPTH);
            set_sel[i]   = set_ch == CHW'(i);
            cmd_pop[i]   = cmd_hs && (M_AXIS_CMD_TDEST == CHW'(i));
            // A full FIFO still takes the push when its head leaves in the same cycle.
            cmd_push[i]  = wr_ctrl && set_sel[i] && (!cmd_full[i] || cmd_pop[i]);
            sts_push[i]  = sts_hs && (S_AXIS_STS_TDEST == CHW'(i));
            sts_pop[i]   = rd_pop && (get_ch == CHW'(i)) && !sts_empty[i];
        end
    end

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!cmd_empty[rr_ptr + CHW'(i)]) begin
                grant     = rr_ptr + CHW'(i);
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_vld) state_nxt = ST_BUSY;
            ST_BUSY: if (cmd_hs)    state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        M_AXIS_CMD_TVALID = state == ST_BUSY;
        load              = (state == ST_IDLE) && grant_vld;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            M_AXIS_CMD_TDATA <= '0;
            M_AXIS_CMD_TDEST <= '0;
            rr_ptr           <= '0;
        end else begin
            if (load) begin
                M_AXIS_CMD_TDATA <= {4'h0, cmd_mem[grant][cmd_rd[grant][CAW-1:0]]};
                M_AXIS_CMD_TDEST <= grant;
            end
            if (cmd_hs) rr_ptr <= M_AXIS_CMD_TDEST + CHW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cmd_push[i]) cmd_mem[i][cmd_wr[i][CAW-1:0]] <= {tag_cnt[i], addr_stage[i], set_data};
            if (sts_push[i]) sts_mem[i][sts_wr[i][SAW-1:0]] <= S_AXIS_STS_TDATA;
        end
    end

    // stall_tmr reaches zero on the 257th consecutive cycle of a blocked status byte.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            running   <= 1'b0;
            stall_tmr <= 9'd256;
            cmd_ovf   <= '0;
            sts_ovf   <= '0;
            for (int i = 0; i < N; i++) begin
                addr_stage[i] <= '0;
                tag_cnt[i]    <= '0;
                issued_cnt[i] <= '0;
                done_cnt[i]   <= '0;
                cmd_wr[i]     <= '0;
                cmd_rd[i]     <= '0;
                sts_wr[i]     <= '0;
                sts_rd[i]     <= '0;
            end
        end else begin
            running   <= 1'b1;
            stall_tmr <= !sts_stall ? 9'd256 : (stall_tmr == '0) ? '0 : stall_tmr - 9'd1;
            for (int i = 0; i < N; i++) begin
                if (wr_addr && set_sel[i]) addr_stage[i] <= set_data;
                if (wr_stat && set_sel[i]) begin
                    cmd_ovf[i] <= 1'b0;
                    sts_ovf[i] <= 1'b0;
                end
                if (wr_ctrl && set_sel[i] && !cmd_push[i]) cmd_ovf[i] <= 1'b1;
                if (sts_stall && stall_tmr == '0 && S_AXIS_STS_TDEST == CHW'(i)) sts_ovf[i] <= 1'b1;
                if (cmd_push[i]) begin
                    cmd_wr[i]  <= cmd_wr[i] + 1'b1;
                    tag_cnt[i] <= tag_cnt[i] + 1'b1;
                end
                if (cmd_pop[i]) begin
                    cmd_rd[i]     <= cmd_rd[i] + 1'b1;
                    issued_cnt[i] <= issued_cnt[i] + 1'b1;
                end
                if (sts_push[i]) begin
                    sts_wr[i]   <= sts_wr[i] + 1'b1;
                    done_cnt[i] <= done_cnt[i] + 1'b1;
                end
                if (sts_pop[i]) sts_rd[i] <= sts_rd[i] + 1'b1;
            end
        end
    end

`ifdef ACCEL_DMA_CMD_IRQ_EN
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            irq <= '0;
            for (int i = 0; i < N; i++) irq_mask[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_mask && set_sel[i]) irq_mask[i] <= set_data[1:0];
                irq[i] <= (irq_mask[i][0] && !sts_empty[i]) ||
                          (irq_mask[i][1] && (cmd_ovf[i] || sts_ovf[i]));
            end
        end
    end
`endif

    always_comb begin
        get_data = '0;
        if (get_hit) begin
            case (get_ofs)
                OFS_ADDR:   get_data = addr_stage[get_ch];
                OFS_STAT:   get_data = {cmd_ovf[get_ch], sts_ovf[get_ch], 6'b0, 8'(sts_cnt[get_ch]),
                                        8'b0, 8'(cmd_cnt[get_ch])};
                OFS_POP:    if (!sts_empty[get_ch])
                                get_data = {23'b0, 1'b1, sts_mem[get_ch][sts_rd[get_ch][SAW-1:0]]};
                OFS_ISSUED: get_data = issued_cnt[get_ch];
                OFS_DONE:   get_data = done_cnt[get_ch];
`ifdef ACCEL_DMA_CMD_IRQ_EN
                OFS_MASK:   get_data = {30'b0, irq_mask[get_ch]};
`endif
                default:    get_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_accel_dma_cmd_engine.sv
// Directed bench for accel_dma_cmd_engine: register map, arbitration order, latency,
// overflow flags and status routing against hand-computed values.
`timescale 1ns/1ps
module tb_accel_dma_cmd_engine;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] set_addr, set_data, get_addr, get_data;
    logic        set_stb, get_stb;
    logic        cmd_tvalid, cmd_tready, sts_tvalid, sts_tready;
    logic [71:0] cmd_tdata;
    logic [1:0]  cmd_tdest, sts_tdest;
    logic [7:0]  sts_tdata;
`ifdef ACCEL_DMA_CMD_IRQ_EN
    logic [N-1:0] irq;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0]  dest_q [$];
    logic [71:0] data_q [$];

    accel_dma_cmd_engine dut (
        .clk(clk), .aresetn(aresetn),
        .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
        .get_addr(get_addr), .get_data(get_data), .get_stb(get_stb),
        .M_AXIS_CMD_TVALID(cmd_tvalid), .M_AXIS_CMD_TREADY(cmd_tready),
        .M_AXIS_CMD_TDATA(cmd_tdata), .M_AXIS_CMD_TDEST(cmd_tdest),
        .S_AXIS_STS_TVALID(sts_tvalid), .S_AXIS_STS_TREADY(sts_tready),
        .S_AXIS_STS_TDATA(sts_tdata), .S_AXIS_STS_TDEST(sts_tdest)
`ifdef ACCEL_DMA_CMD_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (aresetn && cmd_tvalid && cmd_tready) begin
            dest_q.push_back(cmd_tdest);
            data_q.push_back(cmd_tdata);
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pa(input int ch, input int ofs);
        return 32'(ch << 12) | 32'(ofs);
    endfunction

    task automatic reg_wr(input int ch, input int ofs, input logic [31:0] d);
        @(negedge clk);
        set_addr = pa(ch, ofs);
        set_data = d;
        set_stb  = 1'b1;
        @(posedge clk);
        #1 set_stb = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int ch, input int ofs, input bit pop,
                          input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        get_addr = pa(ch, ofs);
        get_stb  = pop;
        #1 d = get_data;
        @(posedge clk);
        #1 get_stb = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        int k = 0;
        while (dest_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, dest_q.size(), n);
    endtask

    initial begin
        logic [31:0] c;
        int k;
        aresetn = 1'b0; set_addr = '0; set_data = '0; set_stb = 1'b0;
        get_addr = '0; get_stb = 1'b0; cmd_tready = 1'b0;
        sts_tvalid = 1'b0; sts_tdata = '0; sts_tdest = '0;

        repeat (3) @(negedge clk);
        chk("rst_tvalid", cmd_tvalid, 0);
        chk("rst_sts_tready", sts_tready, 0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("run_sts_tready", sts_tready, 1);
        rd_chk("rst_stat0", 0, 'h08, 0, 32'h0);
        rd_chk("rst_issued0", 0, 'h10, 0, 32'h0);

        // Command FIFO overflow on ch0, then push into a full FIFO while its head pops.
        reg_wr(0, 'h00, 32'hA000_0000);
        rd_chk("addr_rb", 0, 'h00, 0, 32'hA000_0000);
        for (int i = 0; i < 9; i++) reg_wr(0, 'h04, 32'(i));
        rd_chk("ovf_stat", 0, 'h08, 0, 32'h8000_0008);
        reg_wr(0, 'h08, 32'h0);
        rd_chk("ovf_clr", 0, 'h08, 0, 32'h0000_0008);
        dest_q.delete(); data_q.delete();
        @(negedge clk);
        cmd_tready = 1'b1;
        set_addr = pa(0, 'h04); set_data = 32'h99; set_stb = 1'b1;
        @(posedge clk);
        #1 set_stb = 1'b0;
        cmd_tready = 1'b0;
        rd_chk("full_push_pop", 0, 'h08, 0, 32'h0000_0008);
        cmd_tready = 1'b1;
        wait_q(9, 60, "drain_cnt");
        for (int i = 0; i < 9; i++) begin
            c = (i == 8) ? 32'h99 : 32'(i);
            chk("drain_data", data_q[i], {8'(i), 32'hA000_0000, c});
        end
        rd_chk("issued0_9", 0, 'h10, 0, 32'd9);
        rd_chk("stat0_empty", 0, 'h08, 0, 32'h0);

        // ch1 latency and hold under back-pressure.
        cmd_tready = 1'b0;
        reg_wr(1, 'h00, 32'h1000_0000);
        reg_wr(1, 'h04, 32'h0080_0100);
        @(negedge clk);
        chk("lat_t1", cmd_tvalid, 0);
        @(negedge clk);
        chk("lat_t2", cmd_tvalid, 1);
        chk("t1_tdata", cmd_tdata, 72'h0_0_10000000_00800100);
        chk("t1_tdest", cmd_tdest, 1);
        dest_q.delete(); data_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_tdata", cmd_tdata, 72'h0_0_10000000_00800100);
        end
        chk("hold_tdest", cmd_tdest, 1);
        @(negedge clk);
        cmd_tready = 1'b1;
        @(posedge clk);
        #1 cmd_tready = 1'b0;
        @(negedge clk);
        chk("one_pop_tvalid", cmd_tvalid, 0);
        repeat (4) @(negedge clk);
        chk("one_pop_cnt", dest_q.size(), 1);
        rd_chk("issued1", 1, 'h10, 0, 32'd1);
        rd_chk("stat1", 1, 'h08, 0, 32'h0);

        // Burst to ch0, ch2, ch3 with rr_ptr at 2.
        cmd_tready = 1'b1;
        dest_q.delete(); data_q.delete();
        reg_wr(0, 'h04, 32'h1);
        reg_wr(2, 'h04, 32'h2);
        reg_wr(3, 'h04, 32'h3);
        wait_q(3, 30, "burst_cnt");
        chk("burst_d0", dest_q[0], 0);
        chk("burst_d1", dest_q[1], 2);
        chk("burst_d2", dest_q[2], 3);
        rd_chk("issued2", 2, 'h10, 0, 32'd1);
        rd_chk("issued3", 3, 'h10, 0, 32'd1);
        rd_chk("issued0_10", 0, 'h10, 0, 32'd10);

        // Status byte routed to ch2.
        @(negedge clk);
        sts_tdest = 2'd2; sts_tdata = 8'h80; sts_tvalid = 1'b1;
        #1 chk("sts_tready2", sts_tready, 1);
        @(posedge clk);
        #1 sts_tvalid = 1'b0;
        rd_chk("sts_stat2", 2, 'h08, 0, 32'h0001_0000);
        rd_chk("sts_pop2", 2, 'h0C, 1, 32'h180);
        rd_chk("sts_pop2_empty", 2, 'h0C, 1, 32'h0);
        rd_chk("done2", 2, 'h14, 0, 32'd1);
        rd_chk("sts_cnt2", 2, 'h08, 0, 32'h0);

        // Fill ch1 status FIFO, then stall until STS_OVF.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sts_tdest = 2'd1; sts_tdata = 8'(i + 16); sts_tvalid = 1'b1;
        end
        @(negedge clk);
        #1 chk("sts_full_tready", sts_tready, 0);
        get_addr = pa(1, 'h08);
        repeat (256) @(negedge clk);
        #1 chk("sts_ovf_pre", get_data, 32'h0008_0000);
        @(negedge clk);
        #1 chk("sts_ovf_set", get_data, 32'h4008_0000);
        sts_tvalid = 1'b0;
        rd_chk("sts_pop1", 1, 'h0C, 1, 32'h110);
        rd_chk("done1", 1, 'h14, 0, 32'd8);
        reg_wr(1, 'h08, 32'h0);
        rd_chk("sts_ovf_clr", 1, 'h08, 0, 32'h0007_0000);

        // Out-of-range page and unmapped offset.
        reg_wr(4, 'h00, 32'hDEAD_BEEF);
        rd_chk("oor_alias", 0, 'h00, 0, 32'hA000_0000);
        rd_chk("oor_read", 4, 'h00, 0, 32'h0);
        rd_chk("unmapped", 0, 'h1C, 0, 32'h0);

`ifdef ACCEL_DMA_CMD_IRQ_EN
        reg_wr(3, 'h18, 32'h1);
        rd_chk("mask_rb", 3, 'h18, 0, 32'h1);
        @(negedge clk);
        sts_tdest = 2'd3; sts_tdata = 8'h55; sts_tvalid = 1'b1;
        @(posedge clk);
        #1 sts_tvalid = 1'b0;
        @(negedge clk);
        chk("irq3_early", irq[3], 0);
        @(negedge clk);
        chk("irq3_set", irq[3], 1);
        rd_chk("irq3_pop", 3, 'h0C, 1, 32'h155);
        @(negedge clk);
        @(negedge clk);
        chk("irq3_clr", irq[3], 0);
`else
        reg_wr(3, 'h18, 32'h3);
        rd_chk("mask_absent", 3, 'h18, 0, 32'h0);
`endif

        // Reset while a command is presented.
        cmd_tready = 1'b0;
        reg_wr(2, 'h04, 32'h5);
        k = 0;
        while (!cmd_tvalid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("mid_tvalid", cmd_tvalid, 1);
        aresetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", cmd_tvalid, 0);
        aresetn = 1'b1;
        rd_chk("mid_rst_stat", 2, 'h08, 0, 32'h0);
        rd_chk("mid_rst_issued", 2, 'h10, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
